register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 8: register and data-port width in bits.
REQ-002 Parameter NREGS, default 8: register count; power of two, at least 2; ADDR_W = clog2(NREGS).
REQ-003 Parameter ZERO_R0, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 we3  input  1  write enable.
REQ-009 wa3  input  ADDR_W  write address.
REQ-010 wd3  input  DATA_W  write data.
REQ-011 ra1, ra2  input  ADDR_W  read addresses for ports 1 and 2.
REQ-012 saida_rd1, saida_rd2  output  DATA_W  read data for ports 1 and 2.
REQ-013 clr  input  1  request to start a sequential clear.
REQ-014 busy  output  1  high while a clear sequence runs.
REQ-015 wr_drop  output  1  one-cycle pulse when a write is discarded because of a clear.
REQ-016 scan_step  input  1  advances the display scan pointer.
REQ-017 scan_addr  output  ADDR_W  current scan pointer.
REQ-018 scan_data  output  DATA_W  contents of the register at scan_addr.

Function
REQ-019 Reads: saida_rdN is combinational from raN with zero cycles of latency.
REQ-020 Read register 0 with ZERO_R0=1: output is 0 regardless of stored value.
REQ-021 Writes: with we3=1 and state IDLE, regs[wa3] takes wd3 at the rising edge.
REQ-022 Write to register 0 with ZERO_R0=1: the write is silently ignored and wr_drop stays 0.
REQ-023 Bypass: with BYPASS=1, state IDLE, we3=1, raN==wa3 and the write not suppressed by REQ-022, saida_rdN equals wd3 in the same cycle.
REQ-024 With BYPASS=0, a same-cycle write is not visible; the read returns the old value.
REQ-025 FSM states are IDLE and CLEAR.
REQ-026 IDLE to CLEAR occurs when clr=1 at an edge; clear index is then set to 0.
REQ-027 CLEAR behaviour: each edge zeroes regs[idx] and increments idx; at idx==NREGS-1 the register is zeroed and the FSM returns to IDLE; clear takes exactly NREGS cycles.
REQ-028 busy is 1 exactly while in CLEAR; it is registered, not derived from clr.
REQ-029 clr asserted while in CLEAR is ignored; no restart, no extension.
REQ-030 we3=1 while in CLEAR: the write is discarded, no register changes, and wr_drop=1 on the following cycle; otherwise wr_drop=0.
REQ-031 Reads during CLEAR return current contents: cleared registers read 0, uncleared ones keep old values; bypass is disabled.
REQ-032 Scan: each edge with scan_step=1 sets scan_addr to scan_addr+1 modulo NREGS, wrapping from NREGS-1 to 0.
REQ-033 scan_data is combinational from scan_addr and obeys REQ-020; scan_step runs independently of the FSM state.
REQ-034 No arithmetic is performed on data; all index counters wrap at NREGS with no overflow flag.

Reset
REQ-035 rst=0 immediately sets all registers to 0, FSM to IDLE, clear index to 0, scan_addr to 0, busy to 0 and wr_drop to 0.
REQ-036 Reset asserted mid-clear aborts the sequence; after release the block is in IDLE with all registers 0.
REQ-037 The first active edge after rst deassertion is processed normally.

Structure
REQ-038 Package regfile_pkg holds the FSM state typedef (IDLE, CLEAR) and the default DATA_W and NREGS constants.
REQ-039 One sub-module, regfile_clear_ctrl, contains the FSM, the clear index counter, busy and wr_drop; the storage array and read muxes stay in register_file_mp.

Verification
REQ-040 Scenario 1: write 0xA5 to r3, then ra1=3 -> saida_rd1=0xA5 on the next cycle; ra2=0 -> saida_rd2=0x00.
REQ-041 Scenario 2: BYPASS=1, we3=1, wa3=5, wd3=0x3C, ra1=5 in the same cycle -> saida_rd1=0x3C before the edge.
REQ-042 Scenario 3: ZERO_R0=1, write 0xFF to r0 -> saida_rd1 for ra1=0 stays 0x00 and wr_drop stays 0.
REQ-043 Scenario 4: fill r0..r7 with nonzero values, pulse clr -> busy=1 for 8 cycles; we3 at cycle 3 produces a wr_drop pulse and no write; all registers read 0 afterwards.
REQ-044 Scenario 5: pulse scan_step 9 times from reset -> scan_addr=1, and scan_data matches r1.
REQ-045 Scenario 6: assert rst during cycle 4 of a clear -> busy=0 and all reads 0 immediately; normal writes work after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREGS  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential-clear controller: walks every register index once, flags
// writes that collide with a running clear.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we3,
    output logic              busy,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] clr_idx
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            wr_drop <= (state == CLEAR) && we3;
        end
    end

    // clr while CLEAR falls through untouched: no restart, no extension
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            CLEAR: begin
                idx_nx = idx + ADDR_W'(1);
                if (idx == ADDR_W'(NREGS - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state == CLEAR);
    assign clr_idx = idx;
endmodule

// File: rtl/register_file_mp.sv
// Two-read / one-write register file with optional r0-zero, write bypass,
// sequential clear and a free-running display scan port.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NREGS   = DEF_NREGS,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we3,
    input  logic [$clog2(NREGS)-1:0] wa3,
    input  logic [DATA_W-1:0]        wd3,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [DATA_W-1:0]        saida_rd1,
    output logic [DATA_W-1:0]        saida_rd2,
    input  logic                     clr,
    output logic                     busy,
    output logic                     wr_drop,
    input  logic                     scan_step,
    output logic [$clog2(NREGS)-1:0] scan_addr,
    output logic [DATA_W-1:0]        scan_data
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam int NPORTS = 2;

    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [NPORTS-1:0][ADDR_W-1:0] ra;
    logic [NPORTS-1:0][DATA_W-1:0] rd;
    logic [ADDR_W-1:0]             clr_idx;
    logic                          wr_ok;

    regfile_clear_ctrl #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .we3     (we3),
        .busy    (busy),
        .wr_drop (wr_drop),
        .clr_idx (clr_idx)
    );

    // r0 writes are dropped silently when hardwired to zero
    assign wr_ok = we3 && !busy && !((ZERO_R0 != 0) && (wa3 == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs <= '0;
        else if (busy)
            regs[clr_idx] <= '0;
        else if (wr_ok)
            regs[wa3] <= wd3;
    end

    assign ra = {ra2, ra1};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        always_comb begin
            rd[p] = regs[ra[p]];
            if ((BYPASS != 0) && wr_ok && (wa3 == ra[p]))
                rd[p] = wd3;
            if ((ZERO_R0 != 0) && (ra[p] == '0))
                rd[p] = '0;
        end
    end

    assign saida_rd1 = rd[0];
    assign saida_rd2 = rd[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            scan_addr <= '0;
        else if (scan_step)
            scan_addr <= scan_addr + ADDR_W'(1);
    end

    always_comb begin
        scan_data = regs[scan_addr];
        if ((ZERO_R0 != 0) && (scan_addr == '0))
            scan_data = '0;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default DUT plus a BYPASS=0 / ZERO_R0=0 variant on shared inputs.
module tb_register_file_mp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we3 = 1'b0;
    logic [2:0] wa3 = '0;
    logic [7:0] wd3 = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;
    logic       clr = 1'b0;
    logic       scan_step = 1'b0;

    logic [7:0] rd1, rd2, sdata, nb_rd1, nb_rd2, nb_sdata;
    logic       busy, wr_drop, nb_busy, nb_wr_drop;
    logic [2:0] saddr, nb_saddr;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    register_file_mp u_dut (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .saida_rd1(rd1), .saida_rd2(rd2),
        .clr(clr), .busy(busy), .wr_drop(wr_drop),
        .scan_step(scan_step), .scan_addr(saddr), .scan_data(sdata)
    );

    register_file_mp #(.ZERO_R0(0), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .saida_rd1(nb_rd1), .saida_rd2(nb_rd2),
        .clr(clr), .busy(nb_busy), .wr_drop(nb_wr_drop),
        .scan_step(scan_step), .scan_addr(nb_saddr), .scan_data(nb_sdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3 rst = 1'b0;
        tick();
        tick();
        ra1 = 3'd3;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_drop", wr_drop, 1'b0);
        chk("rst_scan_addr", saddr, 3'd0);
        chk("rst_rd1", rd1, 8'h00);
        chk("rst_nb_rd1", nb_rd1, 8'h00);
        @(negedge clk) rst = 1'b1;
        tick();

        // write r3 then read back; port 2 on r0
        we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5; ra1 = 3'd3; ra2 = 3'd0;
        #1;
        chk("s1_bypass_rd1", rd1, 8'hA5);
        chk("s1_nb_old_rd1", nb_rd1, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("s1_rd1", rd1, 8'hA5);
        chk("s1_rd2_r0", rd2, 8'h00);
        chk("s1_nb_rd1", nb_rd1, 8'hA5);

        // same-cycle bypass
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h3C; ra1 = 3'd5;
        #1;
        chk("s2_bypass_rd1", rd1, 8'h3C);
        chk("s2_nb_no_bypass", nb_rd1, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("s2_rd1", rd1, 8'h3C);

        // r0 write suppression
        we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF; ra1 = 3'd0;
        #1;
        chk("s3_r0_no_bypass", rd1, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("s3_r0_rd1", rd1, 8'h00);
        chk("s3_wr_drop", wr_drop, 1'b0);
        chk("s3_nb_r0_written", nb_rd1, 8'hFF);

        // fill r0..r7 with 0x11,0x22,...,0x88
        for (int i = 0; i < 8; i++) begin
            we3 = 1'b1; wa3 = 3'(i); wd3 = 8'(8'h11 * (i + 1));
            tick();
        end
        we3 = 1'b0; ra1 = 3'd7; ra2 = 3'd3;
        #1;
        chk("s4_fill_r7", rd1, 8'h88);
        chk("s4_fill_r3", rd2, 8'h44);
        ra1 = 3'd0; ra2 = 3'd1;
        #1;
        chk("s4_fill_nb_r0", nb_rd1, 8'h11);
        chk("s4_fill_r1", rd2, 8'h22);

        clr = 1'b1;
        tick();
        clr = 1'b0; ra1 = 3'd7;
        #1;
        chk("s4_busy_c0", busy, 1'b1);
        chk("s4_uncleared_r7", rd1, 8'h88);
        tick();
        tick();
        #1;
        chk("s4_cleared_r1", rd2, 8'h00);
        chk("s4_nb_cleared_r1", nb_rd2, 8'h00);
        // write and re-clr at cycle 3 of the clear
        we3 = 1'b1; wa3 = 3'd7; wd3 = 8'h5A; clr = 1'b1;
        #1;
        chk("s4_no_bypass_busy", rd1, 8'h88);
        tick();
        we3 = 1'b0; clr = 1'b0;
        #1;
        chk("s4_wr_drop_pulse", wr_drop, 1'b1);
        chk("s4_busy_c3", busy, 1'b1);
        tick();
        chk("s4_wr_drop_end", wr_drop, 1'b0);
        n = 4;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("s4_busy_cycles", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i);
            #1;
            chk($sformatf("s4_zero_r%0d", i), rd1, 8'h00);
            chk($sformatf("s4_nb_zero_r%0d", i), nb_rd1, 8'h00);
        end

        // reset during cycle 4 of a clear
        we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h66;
        tick();
        we3 = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        tick();
        ra1 = 3'd6;
        #1;
        chk("s6_pre_rst_r6", rd1, 8'h66);
        chk("s6_pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_r6", rd1, 8'h00);
        chk("s6_rst_nb_r6", nb_rd1, 8'h00);
        @(negedge clk) rst = 1'b1;

        // first edge after release: normal writes
        we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h3E;
        tick();
        wa3 = 3'd0; wd3 = 8'hC3;
        tick();
        we3 = 1'b0; ra1 = 3'd1;
        #1;
        chk("s6_post_rst_r1", rd1, 8'h3E);
        chk("s6_post_rst_busy", busy, 1'b0);

        // scan: 8 steps wraps to 0, 9th lands on r1
        scan_step = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        scan_step = 1'b0;
        #1;
        chk("s5_scan_wrap_addr", saddr, 3'd0);
        chk("s5_scan_r0_zero", sdata, 8'h00);
        chk("s5_nb_scan_r0", nb_sdata, 8'hC3);
        scan_step = 1'b1;
        tick();
        scan_step = 1'b0;
        #1;
        chk("s5_scan_addr", saddr, 3'd1);
        chk("s5_scan_data", sdata, 8'h3E);
        tick();
        chk("s5_scan_hold", saddr, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
